// File: rtl/pipeline_defs_pkg.sv
// Shared pipeline definitions used by the hazard unit and its neighbours.
package pipeline_defs_pkg;

    parameter int unsigned ADDR_WIDTH = 5;

endpackage

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard controller: taken-branch flush, multi-cycle execute stall and
// load-use bubble, plus a saturating stall-cycle counter.
module pipeline_hazard_unit
    import pipeline_defs_pkg::*;
#(
    parameter int unsigned MULTI_CYCLES = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  dec_valid_i,
    input  logic [ADDR_WIDTH-1:0] dec_src1_addr_i,
    input  logic [ADDR_WIDTH-1:0] dec_src2_addr_i,
    input  logic [ADDR_WIDTH-1:0] dec_src3_addr_i,
    input  logic                  dec_src1_used_i,
    input  logic                  dec_src2_used_i,
    input  logic                  dec_src3_used_i,
    input  logic                  ex_valid_i,
    input  logic                  ex_mem_read_i,
    input  logic [ADDR_WIDTH-1:0] ex_dest_addr_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  ex_multi_start_i,
    output logic                  fetch_stall_o,
    output logic                  decode_stall_o,
    output logic                  de_bubble_o,
    output logic                  fd_flush_o,
    output logic                  ex_hold_o,
    output logic                  multi_done_o,
    output logic [15:0]           stall_count_o
);

    typedef enum logic {
        StIdle,
        StMultiBusy
    } state_e;

    // The start cycle counts as the first stall cycle; the down-counter covers the rest.
    localparam logic [3:0] CntLoad = 4'(MULTI_CYCLES - 2);

    state_e      r_state;
    state_e      w_state_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [15:0] r_stall_count;

    logic w_src1_hit;
    logic w_src2_hit;
    logic w_src3_hit;
    logic w_load_use;
    logic w_branch;
    logic w_multi_start;

    assign w_src1_hit    = dec_src1_used_i && (dec_src1_addr_i == ex_dest_addr_i);
    assign w_src2_hit    = dec_src2_used_i && (dec_src2_addr_i == ex_dest_addr_i);
    assign w_src3_hit    = dec_src3_used_i && (dec_src3_addr_i == ex_dest_addr_i);
    assign w_load_use    = ex_valid_i && ex_mem_read_i && dec_valid_i &&
                           (w_src1_hit || w_src2_hit || w_src3_hit);
    assign w_branch      = ex_branch_taken_i && ex_valid_i;
    assign w_multi_start = ex_multi_start_i && ex_valid_i;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        fetch_stall_o  = 1'b0;
        decode_stall_o = 1'b0;
        de_bubble_o    = 1'b0;
        fd_flush_o     = 1'b0;
        ex_hold_o      = 1'b0;
        multi_done_o   = 1'b0;

        if (reset_i) begin
            w_state_next = StIdle;
            w_cnt_next   = 4'd0;
        end else if (w_branch) begin
            fd_flush_o   = 1'b1;
            de_bubble_o  = 1'b1;
            w_state_next = StIdle;
            w_cnt_next   = 4'd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_multi_start) begin
                        fetch_stall_o  = 1'b1;
                        decode_stall_o = 1'b1;
                        ex_hold_o      = 1'b1;
                        w_state_next   = StMultiBusy;
                        w_cnt_next     = CntLoad;
                    end else if (w_load_use) begin
                        fetch_stall_o  = 1'b1;
                        decode_stall_o = 1'b1;
                        de_bubble_o    = 1'b1;
                    end
                end
                StMultiBusy: begin
                    // New starts and load-use are masked until the current op retires.
                    fetch_stall_o  = 1'b1;
                    decode_stall_o = 1'b1;
                    ex_hold_o      = 1'b1;
                    if (r_cnt == 4'd0) begin
                        multi_done_o = 1'b1;
                        w_state_next = StIdle;
                    end else begin
                        w_cnt_next = r_cnt - 4'd1;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                    w_cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall_count <= 16'd0;
        end else if (fetch_stall_o && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count_o = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed self-checking bench for pipeline_hazard_unit (MULTI_CYCLES = 3).
module tb_pipeline_hazard_unit;
    import pipeline_defs_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  reset_i;
    logic                  dec_valid_i;
    logic [ADDR_WIDTH-1:0] dec_src1_addr_i;
    logic [ADDR_WIDTH-1:0] dec_src2_addr_i;
    logic [ADDR_WIDTH-1:0] dec_src3_addr_i;
    logic                  dec_src1_used_i;
    logic                  dec_src2_used_i;
    logic                  dec_src3_used_i;
    logic                  ex_valid_i;
    logic                  ex_mem_read_i;
    logic [ADDR_WIDTH-1:0] ex_dest_addr_i;
    logic                  ex_branch_taken_i;
    logic                  ex_multi_start_i;
    logic                  fetch_stall_o;
    logic                  decode_stall_o;
    logic                  de_bubble_o;
    logic                  fd_flush_o;
    logic                  ex_hold_o;
    logic                  multi_done_o;
    logic [15:0]           stall_count_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pipeline_hazard_unit #(
        .MULTI_CYCLES (3)
    ) u_dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .dec_valid_i       (dec_valid_i),
        .dec_src1_addr_i   (dec_src1_addr_i),
        .dec_src2_addr_i   (dec_src2_addr_i),
        .dec_src3_addr_i   (dec_src3_addr_i),
        .dec_src1_used_i   (dec_src1_used_i),
        .dec_src2_used_i   (dec_src2_used_i),
        .dec_src3_used_i   (dec_src3_used_i),
        .ex_valid_i        (ex_valid_i),
        .ex_mem_read_i     (ex_mem_read_i),
        .ex_dest_addr_i    (ex_dest_addr_i),
        .ex_branch_taken_i (ex_branch_taken_i),
        .ex_multi_start_i  (ex_multi_start_i),
        .fetch_stall_o     (fetch_stall_o),
        .decode_stall_o    (decode_stall_o),
        .de_bubble_o       (de_bubble_o),
        .fd_flush_o        (fd_flush_o),
        .ex_hold_o         (ex_hold_o),
        .multi_done_o      (multi_done_o),
        .stall_count_o     (stall_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Output vector order: {fetch_stall, decode_stall, de_bubble, fd_flush, ex_hold, multi_done}
    function automatic logic [31:0] outs();
        return {26'd0, fetch_stall_o, decode_stall_o, de_bubble_o, fd_flush_o, ex_hold_o,
                multi_done_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        dec_valid_i       = 1'b0;
        dec_src1_addr_i   = '0;
        dec_src2_addr_i   = '0;
        dec_src3_addr_i   = '0;
        dec_src1_used_i   = 1'b0;
        dec_src2_used_i   = 1'b0;
        dec_src3_used_i   = 1'b0;
        ex_valid_i        = 1'b0;
        ex_mem_read_i     = 1'b0;
        ex_dest_addr_i    = '0;
        ex_branch_taken_i = 1'b0;
        ex_multi_start_i  = 1'b0;
    endtask

    // Load to r3 in execute, decode reads r3 on src2.
    task automatic set_load_use();
        ex_valid_i      = 1'b1;
        ex_mem_read_i   = 1'b1;
        ex_dest_addr_i  = 5'd3;
        dec_valid_i     = 1'b1;
        dec_src2_addr_i = 5'd3;
        dec_src2_used_i = 1'b1;
    endtask

    // Advance one full cycle; inputs change and checks happen after the negedge.
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset_i = 1'b1;
        @(negedge clk_i);
        #1;

        // Reset masks outputs combinationally even with a multi start present
        ex_valid_i       = 1'b1;
        ex_multi_start_i = 1'b1;
        #1 check("rst_outs", outs(), 32'h00);
        tick();
        check("rst_cnt", 32'(stall_count_o), 32'd0);
        reset_i = 1'b0;
        clear_inputs();
        #1 check("idle_outs", outs(), 32'h00);
        tick();

        // Load-use on src2
        set_load_use();
        #1 check("lu_src2", outs(), 32'h38);
        tick();
        clear_inputs();
        #1 check("lu_after", outs(), 32'h00);
        check("lu_cnt", 32'(stall_count_o), 32'd1);

        // Same addresses but sources not read: no stall
        set_load_use();
        dec_src2_used_i = 1'b0;
        dec_src1_addr_i = 5'd3;
        #1 check("lu_unused", outs(), 32'h00);
        tick();
        clear_inputs();
        #1 check("lu_unused_cnt", 32'(stall_count_o), 32'd1);

        // Load-use on src3
        ex_valid_i      = 1'b1;
        ex_mem_read_i   = 1'b1;
        ex_dest_addr_i  = 5'd7;
        dec_valid_i     = 1'b1;
        dec_src3_addr_i = 5'd7;
        dec_src3_used_i = 1'b1;
        #1 check("lu_src3", outs(), 32'h38);
        tick();
        clear_inputs();
        #1 check("lu_src3_cnt", 32'(stall_count_o), 32'd2);

        // Multi-cycle op; new start and load-use in cycle 2 must be ignored
        ex_valid_i       = 1'b1;
        ex_multi_start_i = 1'b1;
        #1 check("mc_c1", outs(), 32'h32);
        tick();
        clear_inputs();
        set_load_use();
        ex_multi_start_i = 1'b1;
        #1 check("mc_c2", outs(), 32'h32);
        tick();
        clear_inputs();
        #1 check("mc_c3_done", outs(), 32'h33);
        tick();
        check("mc_after", outs(), 32'h00);
        check("mc_cnt", 32'(stall_count_o), 32'd5);

        // Branch in multi-cycle cycle 2
        ex_valid_i       = 1'b1;
        ex_multi_start_i = 1'b1;
        #1 check("br_c1", outs(), 32'h32);
        tick();
        clear_inputs();
        ex_valid_i        = 1'b1;
        ex_branch_taken_i = 1'b1;
        #1 check("br_flush", outs(), 32'h0C);
        tick();
        clear_inputs();
        #1 check("br_after", outs(), 32'h00);
        check("br_cnt", 32'(stall_count_o), 32'd6);

        // Branch + multi start + load-use together in IDLE: flush only
        set_load_use();
        ex_branch_taken_i = 1'b1;
        ex_multi_start_i  = 1'b1;
        #1 check("all3_flush", outs(), 32'h0C);
        tick();
        clear_inputs();
        #1 check("all3_after", outs(), 32'h00);
        check("all3_cnt", 32'(stall_count_o), 32'd6);

        // Reset in multi-cycle cycle 2
        ex_valid_i       = 1'b1;
        ex_multi_start_i = 1'b1;
        #1 check("rb_c1", outs(), 32'h32);
        tick();
        clear_inputs();
        reset_i = 1'b1;
        #1 check("rb_outs", outs(), 32'h00);
        tick();
        reset_i = 1'b0;
        #1 check("rb_cnt", 32'(stall_count_o), 32'd0);
        check("rb_idle", outs(), 32'h00);
        tick();
        set_load_use();
        #1 check("rb_lu", outs(), 32'h38);
        tick();
        clear_inputs();
        #1 check("rb_lu_cnt", 32'(stall_count_o), 32'd1);

        // Saturation: 65534 stall cycles reach FFFE, then three more hold at FFFF
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        set_load_use();
        repeat (65534) tick();
        check("sat_fffe", 32'(stall_count_o), 32'h0000FFFE);
        tick();
        check("sat_c1", 32'(stall_count_o), 32'h0000FFFF);
        tick();
        tick();
        check("sat_c3", 32'(stall_count_o), 32'h0000FFFF);
        check("sat_outs", outs(), 32'h38);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
PIPELINE_HAZARD_UNIT -- requirements
Module: pipeline_hazard_unit

Interface
REQ-001 Parameter SHALL be: MULTI_CYCLES, default 3, total stall cycles for one multi-cycle execute op (legal range 2..15).
REQ-002 ADDR_WIDTH SHALL come from the shared definitions header.
REQ-003 Ports SHALL be, one per line:
  clk_i  in  1  clock, all state updates on posedge.
  reset_i  in  1  synchronous, active-high reset.
  dec_valid_i  in  1  decode stage holds a valid instruction.
  dec_src1_addr_i / dec_src2_addr_i / dec_src3_addr_i  in  ADDR_WIDTH each  decode source register addresses.
  dec_src1_used_i / dec_src2_used_i / dec_src3_used_i  in  1 each  the corresponding source is actually read.
  ex_valid_i  in  1  execute stage holds a valid instruction.
  ex_mem_read_i  in  1  execute instruction is a load.
  ex_dest_addr_i  in  ADDR_WIDTH  execute destination register.
  ex_branch_taken_i  in  1  execute resolved a taken branch this cycle.
  ex_multi_start_i  in  1  execute instruction needs MULTI_CYCLES cycles.
  fetch_stall_o  out  1  hold PC and fetch/decode register.
  decode_stall_o  out  1  hold decode outputs.
  de_bubble_o  out  1  force is_valid=0 into the decode/execute register.
  fd_flush_o  out  1  force is_valid=0 into the fetch/decode register.
  ex_hold_o  out  1  hold the decode/execute register contents.
  multi_done_o  out  1  one-cycle pulse on the final multi-cycle stall cycle.
  stall_count_o  out  16  saturating count of stall cycles.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and MULTI_BUSY, plus a 4-bit down-counter cnt.
REQ-005 All control outputs SHALL be combinational from state, cnt and the current-cycle inputs (zero-latency Mealy); stall_count_o SHALL be registered.
REQ-006 load_use SHALL = ex_valid_i & ex_mem_read_i & dec_valid_i & (any srcN_used & srcN_addr == ex_dest_addr_i, N=1..3).
REQ-007 Priority SHALL be branch > multi-cycle > load-use.
REQ-008 If ex_branch_taken_i & ex_valid_i in any state: fd_flush_o=1, de_bubble_o=1, all stall/hold outputs=0, next state IDLE, cnt=0, multi_done_o=0.
REQ-009 In IDLE with ex_multi_start_i & ex_valid_i and no branch: fetch_stall_o=decode_stall_o=ex_hold_o=1, de_bubble_o=0; next state MULTI_BUSY; cnt loads MULTI_CYCLES-2.
REQ-010 In MULTI_BUSY with no branch: fetch_stall_o=decode_stall_o=ex_hold_o=1; if cnt==0, multi_done_o=1 and next state IDLE, else cnt decrements.
REQ-011 The multi-cycle stall SHALL therefore last exactly MULTI_CYCLES cycles, including the start cycle.
REQ-012 ex_multi_start_i SHALL be ignored while in MULTI_BUSY.
REQ-013 load_use SHALL be ignored while in MULTI_BUSY.
REQ-014 In IDLE with load_use, no branch and no multi start: fetch_stall_o=decode_stall_o=de_bubble_o=1 and ex_hold_o=0 for that cycle only; the state stays IDLE.
REQ-015 A load to a register whose srcN_used=0 SHALL NOT stall.
REQ-016 stall_count_o SHALL increment by 1 on every non-reset cycle with fetch_stall_o=1.
REQ-017 stall_count_o SHALL saturate at 16'hFFFF and never wrap.
REQ-018 With no condition active, all control outputs SHALL be 0.

Reset
REQ-019 While reset_i=1, all control outputs SHALL be 0 combinationally.
REQ-020 On a clock edge with reset_i=1: state SHALL become IDLE, cnt=0, stall_count_o=0.
REQ-021 Reset SHALL take priority over every other input, including mid-MULTI_BUSY; the first cycle after reset SHALL behave as IDLE.

Verification
REQ-022 Load-use: ex load to r3, dec src2=r3 used -> 1 cycle fetch_stall/decode_stall/de_bubble=1, stall_count 0->1. The same case with src2_used=0 -> no stall.
REQ-023 Multi-cycle, MULTI_CYCLES=3: ex_multi_start_i pulse -> ex_hold_o=1 for 3 cycles, multi_done_o=1 only in cycle 3, then IDLE, stall_count=3.
REQ-024 Branch during MULTI_BUSY, cycle 2 -> fd_flush_o=de_bubble_o=1, ex_hold_o=0 that cycle, next state IDLE, no multi_done_o.
REQ-025 Simultaneous branch, multi start and load_use in IDLE -> flush only, no stall.
REQ-026 reset_i asserted in MULTI_BUSY cycle 2 -> outputs 0 immediately; after release, IDLE and stall_count_o=0.
REQ-027 Force stall_count to 16'hFFFE, then 3 stall cycles -> holds at 16'hFFFF.
